// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed 7-segment scan controller with tear-free double-buffered loads
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   value_in[15:0]  four hex nibbles, digit k = value_in[4k+3:4k]
//   dp_in[3:0]      decimal point per digit
//   load            single-cycle capture strobe
//   load_ack        one-cycle pulse after each capture
//   HEX_out, dp_out nibble and decimal point for the shared decoder
//   DIG_en[3:0]     one-hot digit enable (zero during the blanking gap)
//   frame_done      pulse in the last cycle of digit 3's slot
//
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading-zero digits 1..3.
module display_scan_ctrl #(
  parameter int CLK_HZ       = 50000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  HEX_out,
  output logic        dp_out,
  output logic [3:0]  DIG_en,
  output logic        frame_done
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  typedef enum logic {BLANK, SHOW} state_t;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt;
  logic [1:0]  idx;
  logic [15:0] act_val, pend_val;
  logic [3:0]  act_dp, pend_dp, sup;
  logic        pend_v, slot_end, bnd;
  assign slot_end = cnt == CW'(DIV - 1);
  assign bnd      = slot_end && idx == 2'd3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BLANK;
      cnt      <= '0;
      idx      <= '0;
      act_val  <= '0;
      act_dp   <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_v   <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt      <= slot_end ? '0 : cnt + CW'(1);
      idx      <= slot_end ? idx + 2'd1 : idx;
      load_ack <= load;
      // A load on the boundary bypasses pending so the new frame shows it at once
      if (load && bnd) begin
        act_val <= value_in;
        act_dp  <= dp_in;
        pend_v  <= 1'b0;
      end else if (bnd && pend_v) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        pend_v  <= 1'b0;
      end else if (load) begin
        pend_val <= value_in;
        pend_dp  <= dp_in;
        pend_v   <= 1'b1;
      end
    end
  end
  // State register lines up so SHOW holds exactly while cnt >= BLANK_CYCLES
  always_comb begin
    state_d = slot_end ? BLANK : (cnt == CW'(BLANK_CYCLES - 1)) ? SHOW : state_q;
  end
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    sup    = '0;
    sup[1] = ~|act_val[15:4]  & ~act_dp[1];
    sup[2] = ~|act_val[15:8]  & ~act_dp[2];
    sup[3] = ~|act_val[15:12] & ~act_dp[3];
  end
`else
  assign sup = '0;
`endif
  assign DIG_en     = (state_q == SHOW && !sup[idx]) ? 4'b0001 << idx : 4'b0000;
  assign HEX_out    = act_val[{idx, 2'b00} +: 4];
  assign dp_out     = act_dp[idx];
  assign frame_done = bnd;
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter: CLK_HZ, 50000000, input clock frequency in Hz.
REQ-002 Parameter: SCAN_HZ, 1000, per-digit slot rate in Hz; slot length DIV = CLK_HZ/SCAN_HZ cycles.
REQ-003 Parameter: BLANK_CYCLES, 50, anti-ghosting gap at the start of each slot; must be 1..DIV-1.
REQ-004 Port: clk  input  1  system clock, the only clock.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: value_in  input  16  four hex nibbles; digit k = value_in[4k+3:4k], digit 3 is most significant.
REQ-007 Port: dp_in  input  4  decimal point per digit, bit k belongs to digit k.
REQ-008 Port: load  input  1  single-cycle strobe that captures value_in and dp_in.
REQ-009 Port: load_ack  output  1  one-cycle pulse confirming capture.
REQ-010 Port: HEX_out  output  4  nibble for the shared 7-segment decoder.
REQ-011 Port: dp_out  output  1  decimal point for the shared decoder.
REQ-012 Port: DIG_en  output  4  one-hot digit enable, active-high, common-cathode select.
REQ-013 Port: frame_done  output  1  one-cycle pulse at the end of digit 3's slot.

Function
REQ-014 The block shall keep a prescaler counting 0..DIV-1; a slot ends when it reaches DIV-1, then it wraps to 0.
REQ-015 FSM states: BLANK and SHOW; the block enters BLANK at slot start and moves to SHOW when the prescaler equals BLANK_CYCLES.
REQ-016 In BLANK, DIG_en shall be 4'b0000; in SHOW, DIG_en shall be one-hot at the current digit index idx.
REQ-017 idx shall advance 0->1->2->3->0 at each slot end; frame_done shall pulse in the cycle in which idx wraps 3->0.
REQ-018 HEX_out and dp_out shall be registered from the active register for idx and valid throughout the slot, including BLANK.
REQ-019 On load, value_in and dp_in shall be captured into a pending register, with load_ack high the next cycle.
REQ-020 If load repeats before the frame boundary, the newer capture shall overwrite pending (last wins), and each load shall get its own ack.
REQ-021 At the frame boundary (idx 3->0), a valid pending register shall be copied into the active register and the pending-valid flag cleared.
REQ-022 Load in the same cycle as the boundary shall go straight to the active register, so the new frame displays it; pending-valid shall stay clear.
REQ-023 A mid-frame load shall never change the digits shown in the current frame (no tearing).

Reset
REQ-024 While rst is high: prescaler=0, idx=0, state=BLANK, active=0, pending=0, pending-valid=0.
REQ-025 While rst is high: DIG_en=0, HEX_out=0, dp_out=0, load_ack=0, frame_done=0.
REQ-026 Reset asserted mid-slot or mid-frame shall abort immediately; after release, scanning restarts at digit 0, BLANK state.
REQ-027 A load coincident with rst shall be discarded.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN: when defined, a digit k>0 shall have DIG_en held 0 for its whole slot if its active nibble and all more-significant active nibbles are zero and its dp bit is 0.
REQ-029 Under that macro, digit 0 shall never be suppressed.
REQ-030 When the macro is undefined, all four digits shall be shown every frame regardless of value.

Verification (DIV=8, BLANK_CYCLES=2)
REQ-031 Release reset, no load -> DIG_en 0 for 2 cycles, then 4'b0001 for 6, then digit 1; HEX_out=0; frame_done every 32 cycles.
REQ-032 Load 16'h1A2F, dp_in=4'b0100 mid-frame -> ack next cycle; current frame unchanged; next frame HEX_out F,2,A,1 and dp_out high only in digit 2's slot.
REQ-033 Two loads 16'h1111 then 16'h2222 in one frame -> two acks; next frame shows 2,2,2,2.
REQ-034 Load 16'h00B0 exactly on the frame_done cycle -> new frame immediately shows 0,B,0,0; with LEADING_ZERO_BLANK_EN, DIG_en stays 0 during the digit 2 and digit 3 slots.
REQ-035 Assert rst during digit 2 SHOW -> all outputs 0 that cycle; after release, idx=0 and the BLANK gap repeats; the active value reads 0.
REQ-036 With the macro undefined, load 16'h0000 -> all four slots enable, HEX_out=0.
